// File: rtl/kmer_extractor_if.sv
// kmer_extractor_if: base stream and k-mer result bundle for kmer_extractor.
//   start       capture-request pulse (master -> slave)
//   baseValid   baseIn holds a valid base (master -> slave)
//   baseIn      2-bit base, A=0 C=1 G=2 T=3 (master -> slave)
//   baseReady   slave accepts a base this cycle (slave -> master)
//   kmersOut    packed k-mer array, entry 0 = first window (slave -> master)
//   kmersValid  kmersOut complete and stable (slave -> master)
//   busy        read capture in progress (slave -> master)
//   kmerCount   k-mers written in the current read (slave -> master)
interface kmer_extractor_if #(
    parameter int unsigned K       = 16,
    parameter int unsigned SEQ_LEN = 64
);
    localparam int unsigned NUM_KMERS = SEQ_LEN - K + 1;

    logic                                start;
    logic                                baseValid;
    logic [1:0]                          baseIn;
    logic                                baseReady;
    logic [NUM_KMERS-1:0][2*K-1:0]       kmersOut;
    logic                                kmersValid;
    logic                                busy;
    logic [5:0]                          kmerCount;

    modport master (
        output start, baseValid, baseIn,
        input  baseReady, kmersOut, kmersValid, busy, kmerCount
    );

    modport slave (
        input  start, baseValid, baseIn,
        output baseReady, kmersOut, kmersValid, busy, kmerCount
    );
endinterface

// File: rtl/kmer_extractor.sv
// kmer_extractor: turns one read of SEQ_LEN 2-bit bases into the packed array of
// sliding-window k-mers (oldest base in the MSBs, newest base in bits [1:0]).
//   clk   rising-edge clock
//   rstN  synchronous reset, active HIGH despite the name
//   bus   kmer_extractor_if slave: start/baseValid/baseIn in,
//         baseReady/kmersOut/kmersValid/busy/kmerCount out
module kmer_extractor #(
    parameter int unsigned K       = 16,
    parameter int unsigned SEQ_LEN = 64
) (
    input logic              clk,
    input logic              rstN,
    kmer_extractor_if.slave  bus
);
    localparam int unsigned NUM_KMERS = SEQ_LEN - K + 1;

    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

    state_e                        state_q;
    logic [2*K-1:0]                window_q;
    logic [6:0]                    base_count_q;
    logic [5:0]                    kmer_count_q;
    logic [NUM_KMERS-1:0][2*K-1:0] kmers_q;
    logic                          kmers_valid_q;
    logic                          busy_q;
    logic                          base_ready_q;

    logic [2*K-1:0] window_next;
    logic [6:0]     kmer_idx_wide;
    logic [5:0]     kmer_idx;
    logic           accept;

    assign window_next   = {window_q[2*K-3:0], bus.baseIn};
    // Entry index of the window completed by the base at index base_count_q.
    assign kmer_idx_wide = base_count_q - 7'(K - 1);
    assign kmer_idx      = kmer_idx_wide[5:0];
    // base_ready_q is high exactly in StFill, so this is the handshake.
    assign accept        = bus.baseValid && base_ready_q;

    always_ff @(posedge clk) begin
        if (rstN) begin
            state_q       <= StIdle;
            window_q      <= '0;
            base_count_q  <= '0;
            kmer_count_q  <= '0;
            kmers_q       <= '0;
            kmers_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            base_ready_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        state_q       <= StFill;
                        window_q      <= '0;
                        base_count_q  <= '0;
                        kmer_count_q  <= '0;
                        kmers_valid_q <= 1'b0;
                        busy_q        <= 1'b1;
                        base_ready_q  <= 1'b1;
                    end
                end
                StFill: begin
                    if (accept) begin
                        window_q     <= window_next;
                        base_count_q <= base_count_q + 7'd1;
                        // The first K-1 bases only prime the window.
                        if (base_count_q >= 7'(K - 1)) begin
                            kmers_q[kmer_idx] <= window_next;
                            if (kmer_count_q < 6'(NUM_KMERS)) begin
                                kmer_count_q <= kmer_count_q + 6'd1;
                            end
                        end
                        if (base_count_q == 7'(SEQ_LEN - 1)) begin
                            state_q       <= StDone;
                            kmers_valid_q <= 1'b1;
                            busy_q        <= 1'b0;
                            base_ready_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    busy_q       <= 1'b0;
                    base_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.baseReady  = base_ready_q;
    assign bus.kmersOut   = kmers_q;
    assign bus.kmersValid = kmers_valid_q;
    assign bus.busy       = busy_q;
    assign bus.kmerCount  = kmer_count_q;
endmodule

// File: tb/tb_kmer_extractor.sv
module tb_kmer_extractor;
    localparam int K         = 16;
    localparam int SEQ_LEN   = 64;
    localparam int NUM_KMERS = SEQ_LEN - K + 1;

    logic clk = 1'b0;
    logic rstN;
    int   checks = 0;
    int   errors = 0;

    logic [1:0] seq [SEQ_LEN];
    int         pat [16] = '{3, 0, 1, 2, 2, 0, 3, 3, 2, 0, 3, 3, 0, 2, 0, 1};

    always #5 clk = ~clk;

    kmer_extractor_if #(.K(K), .SEQ_LEN(SEQ_LEN)) bus ();

    kmer_extractor #(.K(K), .SEQ_LEN(SEQ_LEN)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    // Reference: k-mer j is bases j..j+K-1 read as a base-4 number, first base most significant.
    function automatic logic [2*K-1:0] exp_kmer(input int j);
        longint unsigned acc = 0;
        for (int b = 0; b < K; b++) acc = acc * 4 + longint'(seq[j + b]);
        return acc[2*K-1:0];
    endfunction

    function automatic int exp_count(input int accepted);
        return (accepted >= K) ? accepted - K + 1 : 0;
    endfunction

    task automatic fill_periodic();
        for (int i = 0; i < SEQ_LEN; i++) seq[i] = 2'(pat[i % 16]);
    endtask

    task automatic fill_random();
        for (int i = 0; i < SEQ_LEN; i++) seq[i] = 2'($urandom_range(0, 3));
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // mode 0: every cycle, 1: alternate cycles plus a 5-cycle stall, 2: random bubbles.
    // Called on a negedge with the DUT already in FILL.
    task automatic stream_read(input int mode, input int stop_after, input int start_at);
        int   idx = 0;
        int   cyc = 0;
        int   stall = 0;
        bit   stalled = 0;
        logic v;
        while (idx < stop_after) begin
            if (mode == 1 && idx == 32 && !stalled) begin
                stall = 5;
                stalled = 1;
            end
            case (mode)
                1:       v = (cyc % 2 == 0);
                2:       v = ($urandom_range(0, 2) != 0);
                default: v = 1'b1;
            endcase
            if (stall > 0) begin
                v = 1'b0;
                stall--;
            end
            bus.baseValid = v;
            bus.baseIn    = v ? seq[idx] : 2'($urandom_range(0, 3));
            bus.start     = (idx == start_at);
            checks++;
            if (bus.baseReady !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready idx=%0d got=%b want=1", idx, bus.baseReady);
            end
            @(negedge clk);
            cyc++;
            if (v) begin
                idx++;
                checks++;
                if (bus.kmerCount !== 6'(exp_count(idx))) begin
                    errors++;
                    $display("FAIL stream_count idx=%0d got=%0d want=%0d", idx, bus.kmerCount,
                             exp_count(idx));
                end
                if (idx >= K) begin
                    checks++;
                    if (bus.kmersOut[idx-K] !== exp_kmer(idx - K)) begin
                        errors++;
                        $display("FAIL stream_kmer j=%0d got=%h want=%h", idx - K,
                                 bus.kmersOut[idx-K], exp_kmer(idx - K));
                    end
                end
            end
            if (idx < SEQ_LEN) begin
                checks++;
                if (bus.kmersValid !== 1'b0 || bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_midread idx=%0d valid=%b busy=%b want valid=0 busy=1",
                             idx, bus.kmersValid, bus.busy);
                end
            end
            if (cyc > 2000) begin
                errors++;
                $display("FAIL stream_timeout idx=%0d got=%0d cycles want=<=2000", idx, cyc);
                break;
            end
        end
        bus.baseValid = 1'b0;
        bus.start     = 1'b0;
        if (stop_after == SEQ_LEN) begin
            checks++;
            if (bus.kmersValid !== 1'b1 || bus.busy !== 1'b0 || bus.baseReady !== 1'b0) begin
                errors++;
                $display("FAIL done_flags got valid=%b busy=%b ready=%b want 1 0 0",
                         bus.kmersValid, bus.busy, bus.baseReady);
            end
        end
    endtask

    task automatic test_reset();
        rstN = 1'b1;
        bus.start = 1'b1;
        bus.baseValid = 1'b1;
        bus.baseIn = 2'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.baseReady !== 1'b0 || bus.busy !== 1'b0 || bus.kmersValid !== 1'b0 ||
            bus.kmerCount !== 6'd0) begin
            errors++;
            $display("FAIL reset_flags got ready=%b busy=%b valid=%b count=%0d want 0 0 0 0",
                     bus.baseReady, bus.busy, bus.kmersValid, bus.kmerCount);
        end
        for (int j = 0; j < NUM_KMERS; j++) begin
            checks++;
            if (bus.kmersOut[j] !== '0) begin
                errors++;
                $display("FAIL reset_kmer j=%0d got=%h want=0", j, bus.kmersOut[j]);
            end
        end
        bus.start = 1'b0;
        bus.baseValid = 1'b0;
        rstN = 1'b0;
    endtask

    task automatic test_periodic(input string tag, input int mode);
        fill_periodic();
        do_start();
        stream_read(mode, SEQ_LEN, -1);
        checks++;
        if (bus.kmersOut[0] !== 32'hC68F8F21 || bus.kmersOut[1] !== 32'h1A3E3C87) begin
            errors++;
            $display("FAIL %s_k01 got=%h,%h want=c68f8f21,1a3e3c87", tag, bus.kmersOut[0],
                     bus.kmersOut[1]);
        end
        checks++;
        if (bus.kmersOut[16] !== 32'hC68F8F21 || bus.kmersOut[32] !== 32'hC68F8F21 ||
            bus.kmersOut[48] !== 32'hC68F8F21) begin
            errors++;
            $display("FAIL %s_period got=%h,%h,%h want=c68f8f21", tag, bus.kmersOut[16],
                     bus.kmersOut[32], bus.kmersOut[48]);
        end
        checks++;
        if (bus.kmerCount !== 6'd49) begin
            errors++;
            $display("FAIL %s_count got=%0d want=49", tag, bus.kmerCount);
        end
        for (int j = 0; j < NUM_KMERS; j++) begin
            checks++;
            if (bus.kmersOut[j] !== exp_kmer(j)) begin
                errors++;
                $display("FAIL %s_kmer j=%0d got=%h want=%h", tag, j, bus.kmersOut[j],
                         exp_kmer(j));
            end
        end
    endtask

    task automatic test_rerun();
        for (int i = 0; i < SEQ_LEN; i++) seq[i] = 2'd0;
        do_start();
        stream_read(0, SEQ_LEN, -1);
        do_start();
        checks++;
        if (bus.kmersValid !== 1'b0 || bus.busy !== 1'b1 || bus.kmerCount !== 6'd0) begin
            errors++;
            $display("FAIL rerun_restart got valid=%b busy=%b count=%0d want 0 1 0",
                     bus.kmersValid, bus.busy, bus.kmerCount);
        end
        for (int i = 0; i < SEQ_LEN; i++) seq[i] = 2'd3;
        stream_read(0, SEQ_LEN, -1);
        for (int j = 0; j < NUM_KMERS; j++) begin
            checks++;
            if (bus.kmersOut[j] !== 32'hFFFFFFFF) begin
                errors++;
                $display("FAIL rerun_kmer j=%0d got=%h want=ffffffff", j, bus.kmersOut[j]);
            end
        end
        // Result must hold while idle in DONE.
        repeat (3) @(negedge clk);
        checks++;
        if (bus.kmersValid !== 1'b1 || bus.kmersOut[20] !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL rerun_hold got valid=%b k20=%h want 1 ffffffff", bus.kmersValid,
                     bus.kmersOut[20]);
        end
    endtask

    task automatic test_reset_mid();
        fill_random();
        do_start();
        stream_read(2, 30, -1);
        rstN = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        rstN = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (bus.baseReady !== 1'b0 || bus.busy !== 1'b0 || bus.kmerCount !== 6'd0) begin
            errors++;
            $display("FAIL midreset_flags got ready=%b busy=%b count=%0d want 0 0 0",
                     bus.baseReady, bus.busy, bus.kmerCount);
        end
        for (int j = 0; j < NUM_KMERS; j++) begin
            checks++;
            if (bus.kmersOut[j] !== '0) begin
                errors++;
                $display("FAIL midreset_kmer j=%0d got=%h want=0", j, bus.kmersOut[j]);
            end
        end
        test_periodic("after_reset", 0);
    endtask

    task automatic test_ignored();
        rstN = 1'b1;
        @(negedge clk);
        rstN = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.baseValid = 1'b1;
            bus.baseIn = 2'($urandom_range(0, 3));
            @(negedge clk);
            checks++;
            if (bus.baseReady !== 1'b0 || bus.busy !== 1'b0 || bus.kmerCount !== 6'd0 ||
                bus.kmersOut[0] !== '0) begin
                errors++;
                $display("FAIL idle_ignore c=%0d got ready=%b busy=%b count=%0d k0=%h want 0",
                         c, bus.baseReady, bus.busy, bus.kmerCount, bus.kmersOut[0]);
            end
        end
        bus.baseValid = 1'b0;
        fill_random();
        do_start();
        stream_read(0, SEQ_LEN, 20);
        checks++;
        if (bus.kmerCount !== 6'd49) begin
            errors++;
            $display("FAIL fill_start_count got=%0d want=49", bus.kmerCount);
        end
        for (int j = 0; j < NUM_KMERS; j++) begin
            checks++;
            if (bus.kmersOut[j] !== exp_kmer(j)) begin
                errors++;
                $display("FAIL fill_start_kmer j=%0d got=%h want=%h", j, bus.kmersOut[j],
                         exp_kmer(j));
            end
        end
    endtask

    task automatic test_random_reads();
        for (int r = 0; r < 4; r++) begin
            fill_random();
            do_start();
            stream_read(2, SEQ_LEN, -1);
            for (int j = 0; j < NUM_KMERS; j++) begin
                checks++;
                if (bus.kmersOut[j] !== exp_kmer(j)) begin
                    errors++;
                    $display("FAIL random_kmer r=%0d j=%0d got=%h want=%h", r, j,
                             bus.kmersOut[j], exp_kmer(j));
                end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.baseValid = 1'b0;
        bus.baseIn = 2'd0;
        rstN = 1'b1;
        test_reset();
        test_periodic("periodic", 0);
        test_periodic("bubbles", 1);
        test_rerun();
        test_reset_mid();
        test_ignored();
        test_random_reads();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
